// File: rtl/spi_slave_word.sv
// SPI slave that moves WIDTH-bit words between an external SPI master and the clk domain.
// SCK, SSEL and MOSI are oversampled by clk, so SCK must run well below clk/4.
module spi_slave_word #(
  parameter int WIDTH     = 8,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SCK,
  input  logic             SSEL,
  input  logic             MOSI,
  output logic             MISO,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_wr,
  output logic             tx_full,
  output logic             tx_underrun,
  output logic             busy
);

  localparam int   CNT_W    = $clog2(WIDTH);
  localparam logic SCK_IDLE = (CPOL != 0);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] rx_shift;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] tx_hold;
  logic             armed;

  logic sck_p0, sck_p1, sck_p2;
  logic ssel_p0, ssel_p1, ssel_p2;
  logic mosi_p0, mosi_p1, mosi_p2;

  logic sck_lead, sck_trail, sample_edge, shift_edge;
  logic ssel_fall, ssel_rise;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] w, input logic b);
    if (LSB_FIRST != 0) return {b, w[WIDTH-1:1]};
    else                return {w[WIDTH-2:0], b};
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
    if (LSB_FIRST != 0) return {1'b0, w[WIDTH-1:1]};
    else                return {w[WIDTH-2:0], 1'b0};
  endfunction

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    if (LSB_FIRST != 0) return w[0];
    else                return w[WIDTH-1];
  endfunction

  // Stage p0/p1: metastability synchronisers; left free-running so that they
  // always reflect the real pin levels when reset is released.
  always_ff @(posedge clk) begin
    sck_p0  <= SCK;
    sck_p1  <= sck_p0;
    ssel_p0 <= SSEL;
    ssel_p1 <= ssel_p0;
    mosi_p0 <= MOSI;
    mosi_p1 <= mosi_p0;
  end

  // Stage p1 -> p2: edge detection against the history register.
  assign sck_lead    = (sck_p2 == SCK_IDLE) && (sck_p1 != SCK_IDLE);
  assign sck_trail   = (sck_p2 != SCK_IDLE) && (sck_p1 == SCK_IDLE);
  assign sample_edge = (CPHA != 0) ? sck_trail : sck_lead;
  assign shift_edge  = (CPHA != 0) ? sck_lead  : sck_trail;
  assign ssel_fall   = ssel_p2 && !ssel_p1;
  assign ssel_rise   = !ssel_p2 && ssel_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      tx_hold     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_full     <= 1'b0;
      tx_underrun <= 1'b0;
      busy        <= 1'b0;
      armed       <= 1'b0;
      sck_p2      <= SCK_IDLE;
      ssel_p2     <= 1'b1;
      mosi_p2     <= 1'b0;
    end else begin
      sck_p2      <= sck_p1;
      ssel_p2     <= ssel_p1;
      mosi_p2     <= mosi_p1;
      busy        <= !ssel_p1;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      // A select already low when reset lifts is not a fresh frame start.
      if (ssel_p1) armed <= 1'b1;

      if (ssel_rise) begin
        state   <= IDLE;
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (ssel_fall && armed) state <= LOAD;
          end
          LOAD: begin
            if (tx_full) begin
              tx_shift <= tx_hold;
              tx_full  <= 1'b0;
            end else begin
              tx_shift    <= '0;
              tx_underrun <= 1'b1;
            end
            state <= SHIFT;
          end
          SHIFT: begin
            if (sample_edge) begin
              if (bit_cnt == LAST_BIT) begin
                rx_data  <= shift_in(rx_shift, mosi_p2);
                rx_valid <= 1'b1;
                bit_cnt  <= '0;
                state    <= LOAD;
              end else begin
                rx_shift <= shift_in(rx_shift, mosi_p2);
                bit_cnt  <= bit_cnt + 1'b1;
              end
            end
            // The first bit is already on MISO from LOAD, so the shift edge
            // that precedes (CPHA=1) or trails (CPHA=0) a word boundary is skipped.
            if (shift_edge && (bit_cnt != '0)) tx_shift <= shift_out(tx_shift);
          end
          default: state <= IDLE;
        endcase
      end

      // Placed last so a write coincident with LOAD keeps the register full.
      if (tx_wr) begin
        tx_hold <= tx_data;
        tx_full <= 1'b1;
      end
    end
  end

  always_comb begin
    MISO = 1'b0;
    case (state)
      LOAD:    MISO = tx_full & head_bit(tx_hold);
      SHIFT:   MISO = head_bit(tx_shift);
      default: MISO = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_spi_slave_word.sv
// Bench for spi_slave_word: an 8-bit mode-0 MSB-first instance (a) and a 16-bit
// CPOL=1/CPHA=1/LSB-first instance (b), driven by a bit-level SPI master model.
module tb_spi_slave_word;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sck_a = 1'b0, ssel_a = 1'b1, mosi_a = 1'b0;
  logic        miso_a, rx_valid_a, tx_full_a, tx_underrun_a, busy_a;
  logic [7:0]  rx_data_a;
  logic [7:0]  tx_data_a = '0;
  logic        tx_wr_a = 1'b0;

  logic        sck_b = 1'b1, ssel_b = 1'b1, mosi_b = 1'b0;
  logic        miso_b, rx_valid_b, tx_full_b, tx_underrun_b, busy_b;
  logic [15:0] rx_data_b;
  logic [15:0] tx_data_b = '0;
  logic        tx_wr_b = 1'b0;

  spi_slave_word #(.WIDTH(8), .CPOL(0), .CPHA(0), .LSB_FIRST(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .SCK(sck_a), .SSEL(ssel_a), .MOSI(mosi_a), .MISO(miso_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .tx_data(tx_data_a), .tx_wr(tx_wr_a),
    .tx_full(tx_full_a), .tx_underrun(tx_underrun_a), .busy(busy_a)
  );

  spi_slave_word #(.WIDTH(16), .CPOL(1), .CPHA(1), .LSB_FIRST(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .SCK(sck_b), .SSEL(ssel_b), .MOSI(mosi_b), .MISO(miso_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .tx_data(tx_data_b), .tx_wr(tx_wr_b),
    .tx_full(tx_full_b), .tx_underrun(tx_underrun_b), .busy(busy_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int und_cnt_a = 0;
  logic [31:0] exp_rx_a[$];
  logic [31:0] exp_rx_b[$];
  logic [31:0] last_rx_a = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Received-word scoreboard: every rx_valid must match the oldest pushed word.
  always @(negedge clk) begin
    if (rx_valid_a) begin
      if (exp_rx_a.size() == 0) check("rx_a_unexpected_valid", 32'(rx_data_a), 32'hFFFF_FFFF);
      else check("rx_a", 32'(rx_data_a), exp_rx_a.pop_front());
    end
    if (rx_valid_b) begin
      if (exp_rx_b.size() == 0) check("rx_b_unexpected_valid", 32'(rx_data_b), 32'hFFFF_FFFF);
      else check("rx_b", 32'(rx_data_b), exp_rx_b.pop_front());
    end
    if (tx_underrun_a) und_cnt_a++;
  end

  function automatic logic get_rxv(input int sel);
    return (sel != 0) ? rx_valid_b : rx_valid_a;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel != 0) ? busy_b : busy_a;
  endfunction

  function automatic logic get_miso(input int sel);
    return (sel != 0) ? miso_b : miso_a;
  endfunction

  task automatic set_sck(input int sel, input logic v);
    if (sel != 0) sck_b = v; else sck_a = v;
  endtask

  task automatic set_mosi(input int sel, input logic v);
    if (sel != 0) mosi_b = v; else mosi_a = v;
  endtask

  task automatic set_ssel(input int sel, input logic v);
    if (sel != 0) ssel_b = v; else ssel_a = v;
  endtask

  // One SCK half period; optionally checks rx_valid latency after a final sample edge.
  task automatic half(input int sel, input bit chk);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (chk && j < 4)
        check($sformatf("rx_valid_lat%0d_%s", j, (sel != 0) ? "b" : "a"),
              32'(get_rxv(sel)), 32'(j == 2));
    end
  endtask

  task automatic spi_select(input int sel);
    @(negedge clk);
    set_ssel(sel, 1'b0);
    repeat (10) @(negedge clk);
    check("busy_selected", 32'(get_busy(sel)), 32'd1);
  endtask

  task automatic spi_deselect(input int sel);
    @(negedge clk);
    set_ssel(sel, 1'b1);
    repeat (10) @(negedge clk);
    check("busy_deselected", 32'(get_busy(sel)), 32'd0);
  endtask

  // Master side of one word; rst_at >= 0 pulses rst_n for one clk before that bit.
  task automatic spi_word(input int sel, input logic [31:0] word, input int nbits,
                          input bit chk_lat, input int rst_at, output logic [31:0] miso_word);
    int  w    = (sel != 0) ? 16 : 8;
    bit  cpol = (sel != 0);
    bit  cpha = (sel != 0);
    bit  lsb  = (sel != 0);
    int  idx;
    logic rd;
    miso_word = '0;
    if (nbits == w && rst_at < 0) begin
      if (sel != 0) exp_rx_b.push_back(word);
      else begin
        exp_rx_a.push_back(word);
        last_rx_a = word;
      end
    end
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_mid_word_outputs",
              32'({miso_a, rx_valid_a, tx_full_a, tx_underrun_a, busy_a, rx_data_a}), 32'd0);
        last_rx_a = '0;
      end
      idx = lsb ? i : (w - 1 - i);
      if (!cpha) begin
        set_mosi(sel, word[idx]);
        half(sel, 1'b0);
        set_sck(sel, ~cpol);
        rd = get_miso(sel);
        half(sel, chk_lat && (i == nbits - 1));
        set_sck(sel, cpol);
      end else begin
        set_sck(sel, ~cpol);
        set_mosi(sel, word[idx]);
        half(sel, 1'b0);
        set_sck(sel, cpol);
        rd = get_miso(sel);
        half(sel, chk_lat && (i == nbits - 1));
      end
      miso_word[idx] = rd;
    end
    half(sel, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] mw;
    int und0;

    repeat (5) @(negedge clk);
    check("reset_outputs_a",
          32'({miso_a, rx_valid_a, tx_full_a, tx_underrun_a, busy_a, rx_data_a}), 32'd0);
    check("reset_outputs_b",
          32'({miso_b, rx_valid_b, tx_full_b, tx_underrun_b, busy_b, rx_data_b}), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy_a", 32'(busy_a), 32'd0);

    // Preloaded word goes out, then an empty register underruns.
    tx_data_a = 8'hA5;
    tx_wr_a   = 1'b1;
    @(negedge clk);
    tx_wr_a   = 1'b0;
    check("tx_full_after_write", 32'(tx_full_a), 32'd1);
    spi_select(0);
    check("tx_full_after_load", 32'(tx_full_a), 32'd0);
    check("no_underrun_when_full", 32'(und_cnt_a), 32'd0);
    und0 = und_cnt_a;
    spi_word(0, 32'hEA, 8, 1'b1, -1, mw);
    check("miso_a5", mw, 32'hA5);
    check("underrun_next_word", 32'(und_cnt_a - und0), 32'd1);
    spi_word(0, 32'h01, 8, 1'b0, -1, mw);
    check("miso_underrun_zero", mw, 32'h00);
    spi_deselect(0);
    check("rx_data_hold", 32'(rx_data_a), 32'h01);

    // Last write wins.
    tx_data_a = 8'h11;
    tx_wr_a   = 1'b1;
    @(negedge clk);
    tx_data_a = 8'h22;
    @(negedge clk);
    tx_wr_a   = 1'b0;
    spi_select(0);
    spi_word(0, 32'h5A, 8, 1'b0, -1, mw);
    check("miso_last_write_wins", mw, 32'h22);
    spi_deselect(0);

    // Write coincident with LOAD: old word sent, new word kept.
    tx_data_a = 8'h33;
    tx_wr_a   = 1'b1;
    @(negedge clk);
    tx_wr_a   = 1'b0;
    @(negedge clk);
    ssel_a = 1'b0;
    repeat (3) @(negedge clk);
    tx_data_a = 8'h44;
    tx_wr_a   = 1'b1;
    @(negedge clk);
    tx_wr_a   = 1'b0;
    check("tx_full_kept_on_load_write", 32'(tx_full_a), 32'd1);
    repeat (8) @(negedge clk);
    spi_word(0, 32'h77, 8, 1'b0, -1, mw);
    check("miso_old_word_on_load_write", mw, 32'h33);
    spi_word(0, 32'h81, 8, 1'b0, -1, mw);
    check("miso_new_word_next", mw, 32'h44);
    spi_deselect(0);

    // Partial word is dropped; full word afterwards is received.
    spi_select(0);
    spi_word(0, 32'hFF, 5, 1'b0, -1, mw);
    spi_deselect(0);
    check("rx_data_after_partial", 32'(rx_data_a), last_rx_a);
    spi_select(0);
    spi_word(0, 32'h3C, 8, 1'b0, -1, mw);
    spi_deselect(0);
    check("rx_data_3c", 32'(rx_data_a), 32'h3C);

    // Reset mid-word aborts the frame; re-selected frame works.
    spi_select(0);
    spi_word(0, 32'hC3, 8, 1'b0, 4, mw);
    spi_deselect(0);
    check("rx_data_after_reset_frame", 32'(rx_data_a), 32'h00);
    spi_select(0);
    spi_word(0, 32'h96, 8, 1'b0, -1, mw);
    spi_deselect(0);
    check("rx_data_96", 32'(rx_data_a), 32'h96);

    // SCK activity while deselected is ignored.
    for (int k = 0; k < 16; k++) begin
      sck_a  = ~sck_a;
      mosi_a = k[1];
      repeat (6) @(negedge clk);
    end
    sck_a = 1'b0;
    repeat (10) @(negedge clk);
    check("rx_data_ignores_idle_sck", 32'(rx_data_a), 32'h96);

    // 16-bit, CPOL=1, CPHA=1, LSB first.
    spi_select(1);
    spi_word(1, 32'h1234, 16, 1'b1, -1, mw);
    spi_word(1, 32'hBEEF, 16, 1'b0, -1, mw);
    spi_deselect(1);
    check("rx_data_b_hold", 32'(rx_data_b), 32'hBEEF);

    repeat (10) @(negedge clk);
    check("rx_a_pending", 32'(exp_rx_a.size()), 32'd0);
    check("rx_b_pending", 32'(exp_rx_b.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
